frame_checker_core: RTL and testbench

- Receive-side counterpart of the colour-bar frame generator. Sinks an 8-bit valid/ready/last byte stream of interleaved pixel planes.
- Regenerates the expected colour-bar pattern and the expected last-beat cadence internally, then counts mismatches.
- Records the first failure and counts completed frames. Status goes to AXI-Lite registers for PYNQ loopback tests of the generator.

---
 rtl/frame_checker_core.sv | 169 ++++++++++++++++
 tb/tb_frame_checker_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_checker_core.sv
// Receive-side colour-bar checker: regenerates the expected byte and last-beat cadence,
// counts mismatches, captures the first data error and counts completed frames.
module frame_checker_core #(
    parameter int NUMPIXELPLANES = 3,
    parameter int CNTW           = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dataIn,
    input  logic        dataInValid,
    input  logic        dataInLast,
    output logic        dataInReady,
    input  logic [31:0] controlRegister,
    input  logic [31:0] heightWidthRegister,
    input  logic [31:0] dataInLastPeriod,
    output logic [15:0] dataErrorCount,
    output logic [15:0] lastErrorCount,
    output logic [15:0] frameCount,
    output logic [31:0] rowColCounter,
    output logic [31:0] firstErrorPos,
    output logic [15:0] firstErrorData,
    output logic        errorSticky
);
    localparam logic [1:0] LAST_PLANE = 2'(NUMPIXELPLANES - 1);

    logic            enable, clear, throttle;
    logic [CNTW-1:0] width, height, quarter_w, half_w, three_q_w;
    logic            red, green, blue, white, plane_on;
    logic [7:0]      expected_byte;
    logic            accept, active, data_err, last_exp, last_err;

    logic            ready_q, ready_d, phase_q, phase_d;
    logic [1:0]      plane_q, plane_d;
    logic [CNTW-1:0] col_q, col_d, row_q, row_d;
    logic [24:0]     beat_q, beat_d;
    logic [15:0]     derr_q, derr_d, lerr_q, lerr_d, frame_q, frame_d, fdata_q, fdata_d;
    logic [31:0]     fpos_q, fpos_d;
    logic            sticky_q, sticky_d;

    // Colour bars split the line into quarters: red, green, blue, white.
    always_comb begin
        enable    = controlRegister[0];
        clear     = controlRegister[1];
        throttle  = controlRegister[2];
        width     = heightWidthRegister[CNTW-1:0];
        height    = heightWidthRegister[16 +: CNTW];
        quarter_w = width >> 2;
        half_w    = width >> 1;
        three_q_w = half_w + quarter_w;
        red       = col_q < quarter_w;
        green     = !red && (col_q < half_w);
        blue      = !red && !green && (col_q < three_q_w);
        white     = !(red || green || blue);
        case (plane_q)
            2'd0:    plane_on = red | white;
            2'd1:    plane_on = green | white;
            default: plane_on = blue | white;
        endcase
        expected_byte = plane_on ? 8'hFF : 8'h00;
        accept   = dataInValid & ready_q;
        active   = accept && (width != '0) && (height != '0);
        data_err = active && (dataIn != expected_byte);
        last_exp = (beat_q == dataInLastPeriod[24:0]);
        last_err = active && (dataInLast != last_exp);
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves one unassigned (which would infer a latch).
        plane_d  = plane_q;
        col_d    = col_q;
        row_d    = row_q;
        beat_d   = beat_q;
        frame_d  = frame_q;
        derr_d   = derr_q;
        lerr_d   = lerr_q;
        fpos_d   = fpos_q;
        fdata_d  = fdata_q;
        sticky_d = sticky_q;
        phase_d  = throttle ? ~phase_q : phase_q;
        ready_d  = enable & ~clear & (~throttle | phase_q);

        if (active) begin
            beat_d = last_exp ? '0 : beat_q + 25'd1;
            if (plane_q == LAST_PLANE) begin
                plane_d = '0;
                if (col_q == width - 1'b1) begin
                    col_d = '0;
                    if (row_q == height - 1'b1) begin
                        row_d   = '0;
                        frame_d = frame_q + 16'd1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                plane_d = plane_q + 2'd1;
            end
        end

        if (data_err && (derr_q != 16'hFFFF)) derr_d = derr_q + 16'd1;
        if (last_err && (lerr_q != 16'hFFFF)) lerr_d = lerr_q + 16'd1;
        if (data_err && !sticky_q) begin
            fpos_d  = (32'(row_q) << 16) | (32'(plane_q) << CNTW) | 32'(col_q);
            fdata_d = {expected_byte, dataIn};
        end
        if (data_err || last_err) sticky_d = 1'b1;

        // Software clear discards everything, including a partial frame.
        if (clear) begin
            phase_d  = 1'b0;
            plane_d  = '0;
            col_d    = '0;
            row_d    = '0;
            beat_d   = '0;
            frame_d  = '0;
            derr_d   = '0;
            lerr_d   = '0;
            fpos_d   = '0;
            fdata_d  = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q  <= 1'b0;
            phase_q  <= 1'b0;
            plane_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            beat_q   <= '0;
            frame_q  <= '0;
            derr_q   <= '0;
            lerr_q   <= '0;
            fpos_q   <= '0;
            fdata_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            ready_q  <= ready_d;
            phase_q  <= phase_d;
            plane_q  <= plane_d;
            col_q    <= col_d;
            row_q    <= row_d;
            beat_q   <= beat_d;
            frame_q  <= frame_d;
            derr_q   <= derr_d;
            lerr_q   <= lerr_d;
            fpos_q   <= fpos_d;
            fdata_q  <= fdata_d;
            sticky_q <= sticky_d;
        end
    end

    assign dataInReady    = ready_q;
    assign dataErrorCount = derr_q;
    assign lastErrorCount = lerr_q;
    assign frameCount     = frame_q;
    assign rowColCounter  = (32'(row_q) << 16) | 32'(col_q);
    assign firstErrorPos  = fpos_q;
    assign firstErrorData = fdata_q;
    assign errorSticky    = sticky_q;

    logic unused_ok;
    assign unused_ok = ^{controlRegister[31:3], heightWidthRegister[15:CNTW],
                         heightWidthRegister[31:16+CNTW], dataInLastPeriod[31:25]};
endmodule

// File: tb/tb_frame_checker_core.sv
// Self-checking bench for frame_checker_core: a beat-count reference model compared every
// cycle, directed scenarios with literal expectations, and randomized streams.
module tb_frame_checker_core;
    localparam int P = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  dataIn = '0;
    logic        dataInValid = 1'b0;
    logic        dataInLast = 1'b0;
    logic        dataInReady;
    logic [31:0] controlRegister = '0;
    logic [31:0] heightWidthRegister = '0;
    logic [31:0] dataInLastPeriod = '0;
    logic [15:0] dataErrorCount, lastErrorCount, frameCount, firstErrorData;
    logic [31:0] rowColCounter, firstErrorPos;
    logic        errorSticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_checker_core #(.NUMPIXELPLANES(P), .CNTW(13)) dut (
        .clk(clk), .reset(reset),
        .dataIn(dataIn), .dataInValid(dataInValid), .dataInLast(dataInLast),
        .dataInReady(dataInReady),
        .controlRegister(controlRegister), .heightWidthRegister(heightWidthRegister),
        .dataInLastPeriod(dataInLastPeriod),
        .dataErrorCount(dataErrorCount), .lastErrorCount(lastErrorCount),
        .frameCount(frameCount), .rowColCounter(rowColCounter),
        .firstErrorPos(firstErrorPos), .firstErrorData(firstErrorData),
        .errorSticky(errorSticky)
    );

    // Reference model state: m_n is the number of checked beats since the last clear/reset.
    int          m_n = 0, m_derr = 0, m_lerr = 0, acc_cnt = 0;
    logic        m_ready = 1'b0, m_phase = 1'b0, m_sticky = 1'b0;
    logic [31:0] m_fpos = '0;
    logic [15:0] m_fdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_w();
        return int'(heightWidthRegister[12:0]);
    endfunction
    function automatic int cur_h();
        return int'(heightWidthRegister[28:16]);
    endfunction
    function automatic int cur_per();
        return int'(dataInLastPeriod[24:0]);
    endfunction

    // Expected byte of beat n: which quarter of the line the pixel sits in decides which plane is lit.
    function automatic logic [7:0] pat_byte(input int n, input int w);
        int plane, col, bar;
        plane = n % P;
        col   = (n / P) % w;
        if (col < w / 4)               bar = 0;
        else if (col < w / 2)          bar = 1;
        else if (col < w / 2 + w / 4)  bar = 2;
        else                           bar = 3;
        return (bar == 3 || bar == plane) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic last_at(input int n, input int per);
        return (n % (per + 1)) == per;
    endfunction

    task automatic model_clear();
        m_n = 0; m_derr = 0; m_lerr = 0;
        m_ready = 1'b0; m_phase = 1'b0; m_sticky = 1'b0;
        m_fpos = '0; m_fdata = '0;
    endtask

    always @(posedge clk or posedge reset) begin : model
        int w, h, per, row, col, plane;
        logic [7:0] exp;
        logic acc, nr;
        if (reset) begin
            model_clear();
        end else begin
            acc = dataInValid && m_ready;
            if (acc) acc_cnt++;
            if (controlRegister[1]) begin
                model_clear();
            end else begin
                w = cur_w(); h = cur_h(); per = cur_per();
                if (acc && w != 0 && h != 0) begin
                    exp = pat_byte(m_n, w);
                    if (dataIn != exp) begin
                        if (m_derr < 65535) m_derr++;
                        if (!m_sticky) begin
                            plane   = m_n % P;
                            col     = (m_n / P) % w;
                            row     = (m_n / (P * w)) % h;
                            m_fpos  = 32'((row << 16) | (plane << 13) | col);
                            m_fdata = {exp, dataIn};
                        end
                        m_sticky = 1'b1;
                    end
                    if (dataInLast != last_at(m_n, per)) begin
                        if (m_lerr < 65535) m_lerr++;
                        m_sticky = 1'b1;
                    end
                    m_n++;
                end
                nr = controlRegister[0] && (!controlRegister[2] || m_phase);
                if (controlRegister[2]) m_phase = !m_phase;
                m_ready = nr;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w, h, erow, ecol, efr;
        w = cur_w(); h = cur_h();
        erow = 0; ecol = 0; efr = 0;
        if (w != 0 && h != 0) begin
            ecol = (m_n / P) % w;
            erow = (m_n / (P * w)) % h;
            efr  = (m_n / (P * w * h)) % 65536;
        end
        check("ready", 32'(dataInReady), 32'(m_ready));
        check("data_err_cnt", 32'(dataErrorCount), 32'(m_derr));
        check("last_err_cnt", 32'(lastErrorCount), 32'(m_lerr));
        check("frame_cnt", 32'(frameCount), 32'(efr));
        check("row_col", rowColCounter, 32'((erow << 16) | ecol));
        check("first_pos", firstErrorPos, m_fpos);
        check("first_data", 32'(firstErrorData), 32'(m_fdata));
        check("sticky", 32'(errorSticky), 32'(m_sticky));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int start, t;
        start = acc_cnt; t = 0;
        dataInValid = 1'b1; dataIn = d; dataInLast = l;
        while (acc_cnt == start && t < 20) begin
            tick();
            t++;
        end
        check("beat_accepted", 32'(acc_cnt - start), 32'd1);
        dataInValid = 1'b0;
    endtask

    task automatic configure(input int w, input int h, input int per, input logic [2:0] ctrl);
        heightWidthRegister = {16'(h), 16'(w)};
        dataInLastPeriod    = 32'(per);
        controlRegister     = 32'd2;
        tick();
        controlRegister     = {29'd0, ctrl};
        tick();
    endtask

    // Sends beats k0..k1-1 of the pattern; beats c1/c2 inverted, last optionally one beat early.
    task automatic stream(input int k0, input int k1, input int c1, input int c2, input logic early);
        logic [7:0] d;
        logic l;
        for (int k = k0; k < k1; k++) begin
            d = pat_byte(k, cur_w());
            if (k == c1 || k == c2) d = d ^ 8'hFF;
            l = early ? last_at(k + 1, cur_per()) : last_at(k, cur_per());
            send(d, l);
        end
    endtask

    initial begin
        int start, w, h, per;
        logic thr;
        logic [7:0] d;
        logic l;

        repeat (3) tick();
        check("rst_ready", 32'(dataInReady), 32'd0);
        check("rst_rowcol", rowColCounter, 32'd0);
        reset = 1'b0;
        tick();

        // Clean two-frame stream, 8x2.
        configure(8, 2, 47, 3'b001);
        stream(0, 96, -1, -1, 1'b0);
        tick();
        check("t1_frames", 32'(frameCount), 32'd2);
        check("t1_derr", 32'(dataErrorCount), 32'd0);
        check("t1_lerr", 32'(lastErrorCount), 32'd0);
        check("t1_sticky", 32'(errorSticky), 32'd0);
        check("t1_rowcol", rowColCounter, 32'd0);

        // Corrupted byte 10 (row 0, col 3, plane 1), then a later one.
        configure(8, 2, 47, 3'b001);
        stream(0, 48, 10, -1, 1'b0);
        tick();
        check("t2_derr", 32'(dataErrorCount), 32'd1);
        check("t2_pos", firstErrorPos, 32'h0000_2003);
        check("t2_data", 32'(firstErrorData), 32'h0000_FF00);
        check("t2_sticky", 32'(errorSticky), 32'd1);
        stream(48, 96, 60, -1, 1'b0);
        tick();
        check("t2_derr2", 32'(dataErrorCount), 32'd2);
        check("t2_pos_kept", firstErrorPos, 32'h0000_2003);
        check("t2_data_kept", 32'(firstErrorData), 32'h0000_FF00);

        // Last one beat early.
        configure(8, 2, 47, 3'b001);
        stream(0, 48, -1, -1, 1'b1);
        tick();
        check("t3_lerr", 32'(lastErrorCount), 32'd2);
        check("t3_derr", 32'(dataErrorCount), 32'd0);

        // Throttle with valid held high.
        configure(8, 2, 47, 3'b101);
        tick();
        start = acc_cnt;
        dataInValid = 1'b1;
        for (int c = 0; c < 96; c++) begin
            dataIn     = pat_byte(m_n, 8);
            dataInLast = last_at(m_n, 47);
            tick();
        end
        dataInValid = 1'b0;
        check("t4_accepts", 32'(acc_cnt - start), 32'd48);
        check("t4_derr", 32'(dataErrorCount), 32'd0);
        check("t4_frames", 32'(frameCount), 32'd1);

        // Asynchronous reset in the middle of a cycle.
        configure(8, 2, 47, 3'b001);
        stream(0, 20, 5, -1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_ready", 32'(dataInReady), 32'd0);
        check("t5_derr", 32'(dataErrorCount), 32'd0);
        check("t5_frames", 32'(frameCount), 32'd0);
        check("t5_rowcol", rowColCounter, 32'd0);
        check("t5_pos", firstErrorPos, 32'd0);
        check("t5_data", 32'(firstErrorData), 32'd0);
        check("t5_sticky", 32'(errorSticky), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        stream(0, 48, -1, -1, 1'b0);
        tick();
        check("t5_frames_after", 32'(frameCount), 32'd1);
        check("t5_derr_after", 32'(dataErrorCount), 32'd0);

        // Zero width: beats accepted, nothing checked.
        configure(0, 2, 47, 3'b001);
        for (int k = 0; k < 10; k++) send(8'($urandom), 1'($urandom));
        tick();
        check("t6_derr", 32'(dataErrorCount), 32'd0);
        check("t6_lerr", 32'(lastErrorCount), 32'd0);
        check("t6_sticky", 32'(errorSticky), 32'd0);

        // Randomized rounds against the model.
        for (int r = 0; r < 4; r++) begin
            w   = int'($urandom_range(1, 12));
            h   = int'($urandom_range(1, 3));
            per = int'($urandom_range(0, 60));
            thr = 1'($urandom % 2);
            configure(w, h, per, {thr, 2'b01});
            for (int c = 0; c < 1500; c++) begin
                d = pat_byte(m_n, w);
                if ($urandom % 20 == 0) d = d ^ 8'($urandom_range(1, 255));
                l = last_at(m_n, per);
                if ($urandom % 20 == 0) l = !l;
                dataIn      = d;
                dataInLast  = l;
                dataInValid = ($urandom % 4) != 0;
                controlRegister = {29'd0, thr, 1'($urandom % 400 == 0), 1'($urandom % 10 != 0)};
                tick();
            end
            dataInValid = 1'b0;
        end

        // Saturation of the data error counter.
        configure(8, 2, 47, 3'b001);
        dataIn = 8'h55; dataInLast = 1'b0; dataInValid = 1'b1;
        repeat (65600) tick();
        dataInValid = 1'b0;
        tick();
        check("t8_sat", 32'(dataErrorCount), 32'h0000_FFFF);
        check("t8_sticky", 32'(errorSticky), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
